// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/control sequencer for a 64-bit RV64I datapath subset.
// Fetches one instruction, then steps its datapath controls through DECODE/EXECUTE(/WRITEBACK).
module control_sequencer #(
    parameter int                  WORDSIZE = 64,
    parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [WORDSIZE-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic [4:0]          rf_addr_a,
    output logic [4:0]          rf_addr_b,
    output logic [4:0]          rf_write_addr,
    output logic                rf_write_en,
    output logic [WORDSIZE-1:0] immediate,
    output logic                mux_0_sel,
    output logic                mux_1_sel,
    output logic                mux_2_sel,
    output logic [2:0]          alu_operation,
    output logic                dm_write_en,
    output logic [WORDSIZE-1:0] pc,
    output logic                retire,
    output logic                halted
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
    } state_t;

    state_t              r_state, w_next;
    logic [WORDSIZE-1:0] r_pc, r_imm, w_imm;
    logic [31:0]         r_instr;

    logic [6:0] w_opcode, w_f7;
    logic [2:0] w_f3, w_r_op;
    logic       w_is_r, w_is_addi, w_is_ld, w_is_sd, w_rd_nz;

    assign w_opcode = r_instr[6:0];
    assign w_f3     = r_instr[14:12];
    assign w_f7     = r_instr[31:25];
    assign w_rd_nz  = (r_instr[11:7] != 5'd0);

    assign w_is_addi = (w_opcode == 7'b0010011) && (w_f3 == 3'b000);
    assign w_is_ld   = (w_opcode == 7'b0000011) && (w_f3 == 3'b011);
    assign w_is_sd   = (w_opcode == 7'b0100011) && (w_f3 == 3'b011);

    always_comb begin
        w_is_r = 1'b0;
        w_r_op = 3'b000;
        if (w_opcode == 7'b0110011) begin
            unique case (w_f3)
                3'b000: begin
                    w_is_r = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                    w_r_op = w_f7[5] ? 3'b001 : 3'b000;
                end
                3'b100:  begin w_is_r = (w_f7 == 7'd0); w_r_op = 3'b100; end
                3'b110:  begin w_is_r = (w_f7 == 7'd0); w_r_op = 3'b011; end
                3'b111:  begin w_is_r = (w_f7 == 7'd0); w_r_op = 3'b010; end
                default: begin w_is_r = 1'b0;           w_r_op = 3'b000; end
            endcase
        end
    end

    // I-type for ADDI/LD, split S-type field for SD, zero otherwise.
    always_comb begin
        w_imm = '0;
        if (w_is_addi || w_is_ld)
            w_imm = {{(WORDSIZE-12){r_instr[31]}}, r_instr[31:20]};
        else if (w_is_sd)
            w_imm = {{(WORDSIZE-12){r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_imm   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && imem_ready)
                r_instr <= imem_rdata;
            if (r_state == S_DECODE)
                r_imm <= w_imm;
            if (retire)
                r_pc <= r_pc + WORDSIZE'(4);
        end
    end

    always_comb begin
        w_next        = r_state;
        imem_req      = 1'b0;
        rf_write_en   = 1'b0;
        mux_0_sel     = 1'b0;
        mux_1_sel     = 1'b0;
        mux_2_sel     = 1'b0;
        alu_operation = 3'b000;
        dm_write_en   = 1'b0;
        retire        = 1'b0;
        halted        = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_next = (w_is_r || w_is_addi || w_is_ld || w_is_sd) ? S_EXECUTE : S_HALT;
            end
            S_EXECUTE: begin
                if (w_is_r) begin
                    mux_1_sel     = 1'b1;
                    alu_operation = w_r_op;
                    rf_write_en   = w_rd_nz;
                    retire        = 1'b1;
                    w_next        = S_FETCH;
                end else if (w_is_addi) begin
                    rf_write_en = w_rd_nz;
                    retire      = 1'b1;
                    w_next      = S_FETCH;
                end else if (w_is_sd) begin
                    dm_write_en = 1'b1;
                    retire      = 1'b1;
                    w_next      = S_FETCH;
                end else begin
                    w_next = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                mux_2_sel   = 1'b1;
                rf_write_en = w_rd_nz;
                retire      = 1'b1;
                w_next      = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: w_next = S_FETCH;
        endcase
    end

    assign imem_addr     = r_pc;
    assign pc            = r_pc;
    assign immediate     = r_imm;
    assign rf_addr_a     = r_instr[19:15];
    assign rf_addr_b     = r_instr[24:20];
    assign rf_write_addr = r_instr[11:7];

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed instructions push expected retire
// snapshots; a negedge monitor pops and compares them whenever retire is high.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    logic        imem_req, rf_write_en, mux_0_sel, mux_1_sel, mux_2_sel, dm_write_en, retire, halted;
    logic [63:0] imem_addr, immediate, pc;
    logic [4:0]  rf_addr_a, rf_addr_b, rf_write_addr;
    logic [2:0]  alu_operation;

    logic        b_imem_req, b_rf_write_en, b_mux_0_sel, b_mux_1_sel, b_mux_2_sel, b_dm_write_en, b_retire, b_halted;
    logic [63:0] b_imem_addr, b_immediate, b_pc;
    logic [4:0]  b_rf_addr_a, b_rf_addr_b, b_rf_write_addr;
    logic [2:0]  b_alu_operation;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_write_addr(rf_write_addr),
        .rf_write_en(rf_write_en), .immediate(immediate),
        .mux_0_sel(mux_0_sel), .mux_1_sel(mux_1_sel), .mux_2_sel(mux_2_sel),
        .alu_operation(alu_operation), .dm_write_en(dm_write_en),
        .pc(pc), .retire(retire), .halted(halted)
    );

    // Second copy reset near the top of the address space to exercise PC wrap.
    control_sequencer #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(b_imem_req), .imem_addr(b_imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .rf_addr_a(b_rf_addr_a), .rf_addr_b(b_rf_addr_b), .rf_write_addr(b_rf_write_addr),
        .rf_write_en(b_rf_write_en), .immediate(b_immediate),
        .mux_0_sel(b_mux_0_sel), .mux_1_sel(b_mux_1_sel), .mux_2_sel(b_mux_2_sel),
        .alu_operation(b_alu_operation), .dm_write_en(b_dm_write_en),
        .pc(b_pc), .retire(b_retire), .halted(b_halted)
    );

    typedef struct {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        m1, m2;
        logic [2:0]  alu;
        logic        rfwe, dmwe;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          nchk = 0;
    int          nerr = 0;
    logic [63:0] exp_pc;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [63:0] imm, input logic m1, input logic m2,
                                input logic [2:0] alu, input logic rfwe, input logic dmwe);
        exp_t x;
        x.pc = exp_pc; x.imm = imm; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd;
        x.m1 = m1; x.m2 = m2; x.alu = alu; x.rfwe = rfwe; x.dmwe = dmwe;
        return x;
    endfunction

    // Monitor: strobes may only appear on a retiring cycle; each retire pops one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (rf_write_en) check("rf_write_en outside retire", 64'(retire), 64'd1);
            if (dm_write_en) check("dm_write_en outside retire", 64'(retire), 64'd1);
            if (retire) begin
                if (q.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL unexpected retire at pc %h", pc);
                end else begin
                    e = q.pop_front();
                    check("ret pc",        pc,                   e.pc);
                    check("ret rs1",       64'(rf_addr_a),       64'(e.rs1));
                    check("ret rs2",       64'(rf_addr_b),       64'(e.rs2));
                    check("ret rd",        64'(rf_write_addr),   64'(e.rd));
                    check("ret immediate", immediate,            e.imm);
                    check("ret mux_0_sel", 64'(mux_0_sel),       64'd0);
                    check("ret mux_1_sel", 64'(mux_1_sel),       64'(e.m1));
                    check("ret mux_2_sel", 64'(mux_2_sel),       64'(e.m2));
                    check("ret alu_op",    64'(alu_operation),   64'(e.alu));
                    check("ret rf_write_en", 64'(rf_write_en),   64'(e.rfwe));
                    check("ret dm_write_en", 64'(dm_write_en),   64'(e.dmwe));
                end
            end
        end
    end

    task automatic reset_dut();
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst imem_req",  64'(imem_req),    64'd1);
        check("rst imem_addr", imem_addr,        64'd0);
        check("rst retire",    64'(retire),      64'd0);
        check("rst halted",    64'(halted),      64'd0);
        check("rst rf_we",     64'(rf_write_en), 64'd0);
        check("rst dm_we",     64'(dm_write_en), 64'd0);
        check("rst immediate", immediate,        64'd0);
        check("rst wrap pc",   b_imem_addr,      64'hFFFF_FFFF_FFFF_FFFC);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_pc = '0;
    endtask

    // Entered just after a rising edge with the DUT in FETCH.
    task automatic run_instr(input string nm, input logic [31:0] ins, input int waits,
                             input int exp_cyc, input exp_t x);
        int cyc;
        bit done;
        q.push_back(x);
        cyc = 0;
        for (int i = 0; i <= waits; i++) begin
            imem_ready = (i == waits);
            imem_rdata = ins;
            @(negedge clk);
            if (i == 0) begin
                check({nm, " imem_req"},  64'(imem_req), 64'd1);
                check({nm, " imem_addr"}, imem_addr,     exp_pc);
            end
            @(posedge clk); #1;
            cyc++;
        end
        imem_ready = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 12 && !done; k++) begin
            @(negedge clk);
            cyc++;
            if (retire) done = 1'b1;
            @(posedge clk); #1;
        end
        check({nm, " retired"}, 64'(done), 64'd1);
        check({nm, " cycles"},  64'(cyc),  64'(exp_cyc));
        exp_pc = exp_pc + 64'd4;
        check({nm, " pc after"}, pc, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_dut();

        run_instr("add",  32'h002081B3, 0, 3, mk(5'd1, 5'd2, 5'd3, 64'd0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0));
        check("wrap pc", b_pc, 64'd0);
        run_instr("addi", 32'hFFF00093, 0, 3, mk(5'd0, 5'd31, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0));
        run_instr("ld",   32'h0080B103, 2, 6, mk(5'd1, 5'd8, 5'd2, 64'd8, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0));
        run_instr("sd",   32'h0020B423, 0, 3, mk(5'd1, 5'd2, 5'd8, 64'd8, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1));
        run_instr("add0", 32'h00000033, 0, 3, mk(5'd0, 5'd0, 5'd0, 64'd0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        run_instr("sub",  32'h407302B3, 0, 3, mk(5'd6, 5'd7, 5'd5, 64'd0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0));
        run_instr("xor",  32'h007342B3, 1, 4, mk(5'd6, 5'd7, 5'd5, 64'd0, 1'b1, 1'b0, 3'b100, 1'b1, 1'b0));
        run_instr("or",   32'h007362B3, 0, 3, mk(5'd6, 5'd7, 5'd5, 64'd0, 1'b1, 1'b0, 3'b011, 1'b1, 1'b0));
        run_instr("and",  32'h007372B3, 0, 3, mk(5'd6, 5'd7, 5'd5, 64'd0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0));

        // Illegal word: FETCH, DECODE, then sticky HALT with imem_ready ignored.
        imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            imem_ready = i[0];
            @(negedge clk);
            check("halt halted",   64'(halted),   64'd1);
            check("halt imem_req", 64'(imem_req), 64'd0);
            check("halt pc",       pc,            exp_pc);
            @(posedge clk); #1;
        end
        reset_dut();
        check("post-halt pc", pc, 64'd0);

        run_instr("add2", 32'h002081B3, 0, 3, mk(5'd1, 5'd2, 5'd3, 64'd0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0));

        // Reset lands on the same edge as a ready fetch: the word must be dropped.
        imem_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0080B103;
        @(posedge clk); #1;
        rst = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
        check("midrst pc",       pc,                64'd0);
        check("midrst imem_req", 64'(imem_req),     64'd1);
        check("midrst retire",   64'(retire),       64'd0);
        check("midrst rf_addr",  64'(rf_write_addr), 64'd0);
        exp_pc = '0;
        @(posedge clk); #1;
        run_instr("addi2", 32'hFFF00093, 0, 3, mk(5'd0, 5'd31, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0));

        check("scoreboard drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
